uart_operand_collector: RTL and testbench

- Sits between the 8N1 UART receiver and the adder/transmit sequencer.
- Synchronises the receiver's rx_done level into the hwclk domain and captures two consecutive bytes as operands A then B.
- Presents A, B and the 9-bit sum on a valid/ready interface.
- Discards a stale first byte after an inter-byte timeout, and counts bytes dropped while a result is pending.

---
 rtl/uart_pkg.sv | 12 +
 rtl/sync_edge_detect.sv | 17 +
 rtl/uart_operand_collector.sv | 63 ++++++
 tb/tb_uart_operand_collector.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART baud constants and operand-collector state encoding
package uart_pkg;
   localparam int CLK_HZ          = 12_000_000;
   localparam int BAUD            = 9600;
   localparam int FRAME_BITS      = 10;
   localparam int TIMEOUT_DEFAULT = 2 * FRAME_BITS * (CLK_HZ / BAUD);
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT_B = 2'd1,
      HOLD   = 2'd2
   } coll_state_t;
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: 2-flop synchroniser plus rising-edge pulse for a level from another clock domain
//   clk    destination clock
//   resetn asynchronous active-low reset
//   d      asynchronous level input
//   pulse  one-cycle pulse in the clk domain per rising edge of d
module sync_edge_detect (
   input  logic clk,
   input  logic resetn,
   input  logic d,
   output logic pulse
);
   logic s1, s2, s3;
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) {s1, s2, s3} <= 3'b000;
      else         {s1, s2, s3} <= {d, s1, s2};
   assign pulse = s2 & ~s3;
endmodule

// File: rtl/uart_operand_collector.sv
// uart_operand_collector: pairs two received bytes into operands A, B and a registered 9-bit sum
//   hwclk/resetn          system clock, asynchronous active-low reset
//   rx_byte/rx_done       receiver byte and its done level (baud-clock domain)
//   op_a/op_b/sum         held result, valid while out_valid, released by out_ready
//   timeout_pulse         one cycle when a lone A is discarded
//   overrun_cnt           saturating count of bytes dropped while a result is held
module uart_operand_collector
   import uart_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
   parameter int CNT_W          = 15
) (
   input  logic       hwclk,
   input  logic       resetn,
   input  logic [7:0] rx_byte,
   input  logic       rx_done,
   output logic [7:0] op_a,
   output logic [7:0] op_b,
   output logic [8:0] sum,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       timeout_pulse,
   output logic [7:0] overrun_cnt
);
   coll_state_t      state, state_nx;
   logic [CNT_W-1:0] cnt;
   logic             byte_evt, take_a, take_b, expire, hs;
   sync_edge_detect u_sync (
      .clk    (hwclk),
      .resetn (resetn),
      .d      (rx_done),
      .pulse  (byte_evt)
   );
   // a byte arriving on the expiry cycle wins over the timeout
   always_comb begin
      take_a   = (state == IDLE) & byte_evt;
      take_b   = (state == WAIT_B) & byte_evt;
      expire   = (state == WAIT_B) & ~byte_evt & (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
      hs       = (state == HOLD) & out_valid & out_ready;
      state_nx = take_a ? WAIT_B : take_b ? HOLD : (expire | hs) ? IDLE : state;
   end
   always_ff @(posedge hwclk or negedge resetn)
      if (!resetn) state <= IDLE;
      else         state <= state_nx;
   always_ff @(posedge hwclk or negedge resetn)
      if (!resetn) begin
         cnt           <= '0;
         op_a          <= 8'd0;
         op_b          <= 8'd0;
         sum           <= 9'd0;
         out_valid     <= 1'b0;
         timeout_pulse <= 1'b0;
         overrun_cnt   <= 8'd0;
      end else begin
         cnt           <= take_a ? '0 : (state == WAIT_B) ? cnt + CNT_W'(1) : cnt;
         op_a          <= take_a ? rx_byte : op_a;
         op_b          <= take_b ? rx_byte : op_b;
         sum           <= take_b ? {1'b0, op_a} + {1'b0, rx_byte} : sum;
         out_valid     <= take_b | (out_valid & ~hs);
         timeout_pulse <= expire;
         overrun_cnt   <= (state == HOLD && byte_evt && overrun_cnt != 8'hFF) ? overrun_cnt + 8'd1 : overrun_cnt;
      end
endmodule

// File: tb/tb_uart_operand_collector.sv
// tb_uart_operand_collector: scoreboard bench for the UART operand collector
module tb_uart_operand_collector;
   import uart_pkg::*;
   localparam int T = TIMEOUT_DEFAULT;
   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [8:0] s;
   } res_t;
   logic       hwclk = 1'b0, resetn = 1'b0, rx_done = 1'b0, out_ready = 1'b1;
   logic [7:0] rx_byte = 8'd0;
   logic [7:0] op_a, op_b, overrun_cnt;
   logic [8:0] sum;
   logic       out_valid, timeout_pulse;
   logic       ov_prev = 1'b0;
   res_t       exp_q[$];
   res_t       mon_r;
   int         n_tests = 0, n_fail = 0, n_tp = 0, tp0;
   uart_operand_collector dut (
      .hwclk         (hwclk),
      .resetn        (resetn),
      .rx_byte       (rx_byte),
      .rx_done       (rx_done),
      .op_a          (op_a),
      .op_b          (op_b),
      .sum           (sum),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .timeout_pulse (timeout_pulse),
      .overrun_cnt   (overrun_cnt)
   );
   always #5 hwclk = ~hwclk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
      end
   endtask
   task automatic expect_pair(input logic [7:0] a, input logic [7:0] b);
      res_t r;
      r.a = a;
      r.b = b;
      r.s = {1'b0, a} + {1'b0, b};
      exp_q.push_back(r);
   endtask
   task automatic send(input logic [7:0] b, input int hold = 4);
      @(negedge hwclk);
      rx_byte = b;
      rx_done = 1'b1;
      repeat (hold) @(negedge hwclk);
      rx_done = 1'b0;
      repeat (4) @(negedge hwclk);
   endtask
   task automatic check_zero(input string tag);
      check({tag, "_op_a"}, op_a, 0);
      check({tag, "_op_b"}, op_b, 0);
      check({tag, "_sum"}, sum, 0);
      check({tag, "_valid"}, out_valid, 0);
      check({tag, "_tp"}, timeout_pulse, 0);
      check({tag, "_overrun"}, overrun_cnt, 0);
   endtask
   always @(negedge hwclk) begin
      if (resetn && out_valid && !ov_prev) begin
         check("result_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            mon_r = exp_q.pop_front();
            check("op_a", op_a, mon_r.a);
            check("op_b", op_b, mon_r.b);
            check("sum", sum, mon_r.s);
         end
      end
      if (timeout_pulse) n_tp <= n_tp + 1;
      ov_prev <= out_valid;
   end
   initial begin
      repeat (3) @(negedge hwclk);
      check_zero("reset");
      resetn = 1'b1;
      send(8'h12);
      expect_pair(8'h12, 8'h34);
      @(negedge hwclk);
      rx_byte = 8'h34;
      rx_done = 1'b1;
      @(negedge hwclk) check("lat_e1", out_valid, 0);
      @(negedge hwclk) check("lat_e2", out_valid, 0);
      @(negedge hwclk) check("lat_e3", out_valid, 1);
      @(negedge hwclk) check("valid_one_cycle", out_valid, 0);
      rx_done = 1'b0;
      repeat (4) @(negedge hwclk);
      expect_pair(8'hFF, 8'hFF);
      send(8'hFF);
      send(8'hFF);
      expect_pair(8'h80, 8'h80);
      send(8'h80);
      send(8'h80);
      tp0 = n_tp;
      @(negedge hwclk);
      rx_byte = 8'h55;
      rx_done = 1'b1;
      repeat (4) @(negedge hwclk);
      rx_done = 1'b0;
      repeat (T - 2) @(negedge hwclk);
      check("tp_early", timeout_pulse, 0);
      @(negedge hwclk) check("tp_on_time", timeout_pulse, 1);
      @(negedge hwclk) check("tp_width", timeout_pulse, 0);
      repeat (5) @(negedge hwclk);
      check("tp_count", n_tp - tp0, 1);
      expect_pair(8'h01, 8'h02);
      send(8'h01);
      send(8'h02);
      tp0 = n_tp;
      expect_pair(8'h66, 8'h77);
      @(negedge hwclk);
      rx_byte = 8'h66;
      rx_done = 1'b1;
      repeat (4) @(negedge hwclk);
      rx_done = 1'b0;
      repeat (T - 4) @(negedge hwclk);
      rx_byte = 8'h77;
      rx_done = 1'b1;
      repeat (4) @(negedge hwclk);
      rx_done = 1'b0;
      repeat (4) @(negedge hwclk);
      check("tp_on_expiry", n_tp - tp0, 0);
      expect_pair(8'h07, 8'h09);
      send(8'h07, 1000);
      send(8'h09);
      out_ready = 1'b0;
      expect_pair(8'h10, 8'h20);
      send(8'h10);
      send(8'h20);
      send(8'h31);
      send(8'h32);
      send(8'h33);
      check("bp_valid", out_valid, 1);
      check("bp_sum", sum, 9'h030);
      check("bp_op_a", op_a, 8'h10);
      check("bp_op_b", op_b, 8'h20);
      check("overrun_3", overrun_cnt, 3);
      @(negedge hwclk);
      rx_byte = 8'h44;
      rx_done = 1'b1;
      repeat (2) @(negedge hwclk);
      out_ready = 1'b1;
      @(negedge hwclk);
      out_ready = 1'b0;
      check("hs_valid_drop", out_valid, 0);
      check("overrun_on_hs", overrun_cnt, 4);
      rx_done = 1'b0;
      repeat (4) @(negedge hwclk);
      out_ready = 1'b1;
      expect_pair(8'h5A, 8'hA5);
      send(8'h5A);
      send(8'hA5);
      out_ready = 1'b0;
      expect_pair(8'hC3, 8'h3C);
      send(8'hC3);
      send(8'h3C);
      for (int i = 0; i < 260; i++) send(8'hEE);
      check("overrun_sat", overrun_cnt, 8'hFF);
      check("sat_sum_held", sum, 9'h0FF);
      out_ready = 1'b1;
      repeat (3) @(negedge hwclk);
      send(8'hAA);
      @(negedge hwclk);
      resetn = 1'b0;
      #1;
      check_zero("midrst");
      repeat (2) @(negedge hwclk);
      resetn = 1'b1;
      expect_pair(8'h03, 8'h04);
      send(8'h03);
      send(8'h04);
      repeat (10) @(negedge hwclk);
      check("queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
